sample_sum_accumulator: RTL and testbench
=========================================

Name: sample_sum_accumulator

Overview:
- Sequential accumulation stage wrapped around the team's 32-bit adder (Adder_32).
- Feeds the adder's A operand from a running-sum register and its B operand from the incoming sample.
- Consumes the adder's {C,S} result each accepted sample.
- Sums a programmed number N of 32-bit samples (pixel/feature totals ahead of the 1/N normalisation path), saturating on overflow, and presents the total with a valid/ready handshake.

Parameters:
- DATA_W, 32, sample and sum width; fixed to 32 to match Adder_32.
- CNT_W, 16, width of sample count N and the accepted-sample counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a new accumulation; honoured only in IDLE.
- num_samples  input  CNT_W  N, sampled on accepted start.
- in_valid  input  1  sample present on in_data.
- in_data  input  DATA_W  unsigned sample.
- in_ready  output  1  block accepts a sample this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  downstream takes the result.
- out_sum  output  DATA_W  accumulated (saturated) sum.
- out_ovf  output  1  sticky: a carry occurred during this accumulation.
- out_count  output  CNT_W  number of samples summed (equals latched N).
- busy  output  1  high in ACCUM or HOLD.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE; acc=0; ovf=0; cnt=0; n_lat=0; in_ready=0; out_valid=0; out_sum=0; out_ovf=0; out_count=0; busy=0.
- Reset mid-operation: rst has priority over all other inputs and returns the block to IDLE with all reset values; a partial sum is discarded.
- States:
  - IDLE: in_ready=0, out_valid=0. On start: latch n_lat=num_samples; clear acc, ovf and cnt. If num_samples==0 go to HOLD (sum 0, count 0, ovf 0); otherwise go to ACCUM.
  - ACCUM: in_ready=1. A sample is accepted when in_valid&in_ready. On accept:
    - If ovf or C is set: acc <= 0xFFFFFFFF and ovf <= 1. Otherwise acc <= S.
    - cnt <= cnt+1.
    - If cnt+1==n_lat, go to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_sum, out_ovf and out_count are registered and stable until handshake. On out_ready, go to IDLE.
- Adder operands: A=acc, B=in_data. Only C and S are used; the carry is never added into the sum.
- Latency:
  - A sample accepted in cycle t is reflected in acc at t+1.
  - out_valid rises the cycle after the Nth accept.
  - One sample is accepted per cycle maximum, so back-to-back in_valid gives N cycles of ACCUM.
- Simultaneous events:
  - start in ACCUM or HOLD is ignored; num_samples is not resampled.
  - out_ready in the cycle out_valid first rises completes the transfer; the block is in IDLE the next cycle.
  - start asserted in the IDLE cycle right after a transfer is honoured.
- Boundaries:
  - Once saturated, the sum stays 0xFFFFFFFF for all remaining samples.
  - An exact sum of 0xFFFFFFFF with no carry gives ovf=0.
  - N = 2^CNT_W-1 is supported; cnt never wraps because the comparison ends accumulation first.
  - in_data is ignored whenever in_ready=0.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_ACCUM, ST_HOLD, 2 bits) and the saturation constant SAT_MAX = all-ones of DATA_W.
- One sub-module: instantiate Adder_32 for the sum/carry path. The FSM, counter and registers stay in this module.

Test Plan:
- Reset, then start with N=4; feed 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept; out_sum=10, out_ovf=0, out_count=4; IDLE the next cycle.
- N=3; samples 0xFFFFFFF0, 0x20, 0x5 -> carry on 2nd sample; out_sum=0xFFFFFFFF, out_ovf=1 (remains saturated after the 3rd).
- N=2; samples 0xFFFFFFFE, 0x1 -> out_sum=0xFFFFFFFF, out_ovf=0 (exact fit, no carry).
- N=0 start -> HOLD the next cycle with out_sum=0, out_count=0; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, start pulses ignored.
- N=5 with in_valid gapped (valid every other cycle) and rst asserted after the 3rd accept -> all outputs at reset values the next cycle; a new start with N=1, sample 7 -> out_sum=7.
- Stall test: N=2 result held with out_ready=0; an extra in_valid with data 99 is presented -> not accepted; out_sum unchanged.

Source files
------------

// File: rtl/sample_sum_accumulator_pkg.sv
// Shared constants for the sample sum accumulator: state encoding and saturation value.
package sample_sum_accumulator_pkg;

  localparam int unsigned ADDER_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [ADDER_W-1:0] SAT_MAX = {ADDER_W{1'b1}};

endpackage

// File: rtl/Adder_32.sv
// Team 32-bit unsigned adder: produces sum S and carry-out C of A+B.
module Adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s,
  output logic        c
);

  // Full-width add with carry-out in the extra bit
  always_comb begin
    {c, s} = 33'(a) + 33'(b);
  end

endmodule

// File: rtl/sample_sum_accumulator.sv
// Accumulates N unsigned samples with saturation and presents the total via valid/ready.
module sample_sum_accumulator
  import sample_sum_accumulator_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    n_lat_q, n_lat_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_sum_q, out_sum_d;
  logic                out_ovf_q, out_ovf_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                busy_q, busy_d;

  logic [DATA_W-1:0]   add_s;
  logic                add_c;
  logic                accept;

  // Sum/carry path: A is the running sum, B the incoming sample
  Adder_32 u_adder (
    .a (acc_q),
    .b (in_data),
    .s (add_s),
    .c (add_c)
  );

  assign accept = in_valid && in_ready_q;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    n_lat_d     = n_lat_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_lat_d = num_samples;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = (num_samples == '0) ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          // Once saturated, stay pinned at all-ones; carry is never folded into the sum
          if (ovf_q || add_c) begin
            acc_d = SAT_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = add_s;
          end
          cnt_d = cnt_q + CNT_W'(1);
          // Comparison ends accumulation before cnt can wrap, even for N = 2^CNT_W-1
          if (cnt_d == n_lat_q) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Capture the result once on entry to HOLD so it is stable for the handshake
    if (state_d == ST_HOLD && state_q != ST_HOLD) begin
      out_sum_d   = acc_d;
      out_ovf_d   = ovf_d;
      out_count_d = cnt_d;
    end

    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      n_lat_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_count_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      n_lat_q     <= n_lat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sample_sum_accumulator.sv
// Directed scoreboard bench for sample_sum_accumulator.
module tb_sample_sum_accumulator;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef struct {
    logic [DATA_W-1:0] sum;
    logic              ovf;
    logic [CNT_W-1:0]  count;
  } result_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_samples;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_ovf;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  int      n_checks = 0;
  int      n_errors = 0;
  result_t sb_q[$];

  sample_sum_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_ovf     (out_ovf),
    .out_count   (out_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every completed output transfer against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        result_t e;
        e = sb_q.pop_front();
        chk("sb_sum", 64'(out_sum), 64'(e.sum));
        chk("sb_ovf", 64'(out_ovf), 64'(e.ovf));
        chk("sb_count", 64'(out_count), 64'(e.count));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] s, input logic o, input logic [CNT_W-1:0] c);
    result_t r;
    r.sum = s; r.ovf = o; r.count = c;
    sb_q.push_back(r);
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    start = 1'b1;
    num_samples = n;
    step();
    start = 1'b0;
  endtask

  // Present one sample and hold it until accepted (bounded)
  task automatic feed(input logic [DATA_W-1:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) chk("feed_timeout", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  // Wait until the scoreboard drains (bounded)
  task automatic wait_done();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_ovf", 64'(out_ovf), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // N=4, samples 1..4 back-to-back
    out_ready = 1'b1;
    push_exp(32'd10, 1'b0, 16'd4);
    do_start(16'd4);
    chk("t1_accum_in_ready", 64'(in_ready), 64'(1));
    chk("t1_accum_busy", 64'(busy), 64'(1));
    feed(32'd1); feed(32'd2); feed(32'd3);
    chk("t1_not_yet_valid", 64'(out_valid), 64'(0));
    feed(32'd4);
    chk("t1_valid_after_4th", 64'(out_valid), 64'(1));
    chk("t1_hold_in_ready", 64'(in_ready), 64'(0));
    step();
    chk("t1_idle_valid", 64'(out_valid), 64'(0));
    chk("t1_idle_busy", 64'(busy), 64'(0));
    chk("t1_sb_empty", 64'(sb_q.size()), 64'(0));

    // N=3 saturating on the 2nd sample, stays saturated
    push_exp(32'hFFFF_FFFF, 1'b1, 16'd3);
    do_start(16'd3);
    feed(32'hFFFF_FFF0); feed(32'h20); feed(32'h5);
    wait_done();
    step();

    // N=2 exact fit to all-ones with no carry
    push_exp(32'hFFFF_FFFF, 1'b0, 16'd2);
    do_start(16'd2);
    feed(32'hFFFF_FFFE); feed(32'h1);
    wait_done();
    step();

    // N=0 goes straight to HOLD; held output is stable and start is ignored
    out_ready = 1'b0;
    push_exp(32'd0, 1'b0, 16'd0);
    do_start(16'd0);
    chk("t4_valid", 64'(out_valid), 64'(1));
    chk("t4_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 5; i++) begin
      start = i[0];
      num_samples = 16'd7;
      step();
      chk("t4_hold_valid", 64'(out_valid), 64'(1));
      chk("t4_hold_sum", 64'(out_sum), 64'(0));
      chk("t4_hold_count", 64'(out_count), 64'(0));
      chk("t4_hold_in_ready", 64'(in_ready), 64'(0));
    end
    start = 1'b0;
    out_ready = 1'b1;
    wait_done();
    step();
    chk("t4_idle", 64'(busy), 64'(0));

    // N=5 gapped, reset after the 3rd accept discards the partial sum
    do_start(16'd5);
    feed(32'd100); step();
    feed(32'd200); step();
    feed(32'd300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_in_ready", 64'(in_ready), 64'(0));
    chk("t5_rst_valid", 64'(out_valid), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_sum", 64'(out_sum), 64'(0));
    chk("t5_rst_ovf", 64'(out_ovf), 64'(0));
    chk("t5_rst_count", 64'(out_count), 64'(0));
    push_exp(32'd7, 1'b0, 16'd1);
    do_start(16'd1);
    feed(32'd7);
    wait_done();
    step();

    // Stall: held result, extra sample presented is not accepted
    out_ready = 1'b0;
    push_exp(32'd30, 1'b0, 16'd2);
    do_start(16'd2);
    feed(32'd10); feed(32'd20);
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall_in_ready", 64'(in_ready), 64'(0));
      chk("t6_stall_sum", 64'(out_sum), 64'(30));
      chk("t6_stall_valid", 64'(out_valid), 64'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_done();
    step();
    chk("t6_idle", 64'(busy), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
